pwm_gen: RTL
============

// Module: pwm_gen
// PURPOSE
//   Consumes the free-running N-bit count from the counter block and produces a PWM waveform.
//   Duty cycle arrives over a valid/ready handshake into a shadow register.
//   The shadow value is applied only at a period boundary, so no pulse is ever truncated or glitched.
//   Sits directly downstream of the counter and shares its clock and reset.
// PARAMETERS
//   N         4   width of count input; PWM period = 2**N cycles
// PORTS
//   clk         input   1    system clock; all state updates on posedge
//   aresetn     input   1    reset, synchronous, active-low (sampled on posedge clk)
//   en          input   1    run request
//   count       input   N    counter value (q of upstream counter)
//   duty_valid  input   1    duty word offered
//   duty_ready  output  1    shadow register free to accept a duty word
//   duty        input   N+1  high-time in cycles, 0..2**N; values > 2**N clamp to 2**N
//   pwm         output  1    PWM output, registered
//   wrap        output  1    one-cycle pulse per detected period wrap, registered
//   busy        output  1    state != IDLE
// BEHAVIOUR
//   Reset (aresetn=0 at posedge):
//     - state=IDLE, active=0, shadow=0, pending=0, count_d=0.
//     - Outputs: pwm=0, wrap=0, duty_ready=1, busy=0.
//     - Reset mid-period discards the pending duty word and the current pulse.
//   Wrap detect:
//     - wrap_det = (count==0) && (count_d==2**N-1), where count_d is count delayed one cycle.
//     - wrap <= wrap_det: 1-cycle latency, independent of state.
//     - A jump to 0 from any value other than MAX (upstream reset) is not a wrap.
//   Handshake:
//     - duty_ready = !pending.
//     - Transfer on posedge with duty_valid && duty_ready: shadow <= clamp(duty), pending <= 1.
//     - On wrap_det with pending=1: active <= shadow, pending <= 0. duty_ready rises the following cycle.
//     - Transfer and wrap_det in the same cycle (pending was 0): the word goes to shadow only and applies at the NEXT wrap.
//     - duty_valid held while duty_ready=0 is ignored and not lost; the master keeps offering it.
//   duty_next = (wrap_det && pending) ? shadow : active.
//   FSM states: IDLE, SYNC, RUN, DRAIN.
//     IDLE : pwm<=0. If en -> SYNC.
//     SYNC : pwm<=0, waiting for period alignment.
//            If en=0 -> IDLE.
//            Else on wrap_det -> RUN, pwm <= (0 < duty_next).
//     RUN  : pwm <= (count < duty_next), compared as N+1 bits.
//            If en=0 -> DRAIN, with this cycle's pwm computed as in RUN.
//     DRAIN: pwm <= (count < duty_next) until the period ends.
//            On wrap_det: -> IDLE, pwm<=0.
//            If en=1 and no wrap_det: -> RUN.
//            If wrap_det and en=1 together: -> RUN, pwm computed as in RUN.
//   pwm lags count by exactly one cycle.
//   duty=0 gives constant 0 in RUN; duty=2**N gives constant 1 in RUN.
//   busy = (state != IDLE), registered along with state.
// STRUCTURE
//   Package pwm_pkg:
//     - typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} pwm_state_t.
//     - function clamp_duty(N): saturate to 2**N.
//   Sub-module wrap_detect #(N): count_d register plus compare; outputs wrap_det.
//   Top level holds the FSM, the shadow/active registers and the handshake.
// TESTING  (N=4, upstream counter free-running, duty in cycles)
//   1. Reset: aresetn=0 for 3 cycles while RUN with duty=8 -> pwm=0, wrap=0, busy=0, duty_ready=1,
//      pending duty word discarded.
//   2. duty=5 accepted, en=1 -> busy=1, pwm=0 until first wrap.
//      Then pwm=1 for counts 0..4 and 0 for counts 5..15 every period; wrap pulses every 16 cycles.
//   3. Edge duties: duty=0 -> pwm stuck 0; duty=16 -> stuck 1; duty=20 -> clamped, stuck 1.
//   4. Handshake back-pressure: load duty=3, then hold duty_valid with duty=10.
//      - duty_ready stays 0 until the cycle after wrap; 10 is accepted then.
//      - Period k+1 shows 3 high cycles; period k+2 shows 10.
//   5. Disable mid-period: duty=8, drop en at count=3.
//      - Pulse continues through count 7.
//      - State goes DRAIN -> IDLE at the next wrap; busy falls on the same edge.
//   6. Upstream counter reset mid-period (count 9 -> 0): wrap stays 0; shadow is not applied;
//      pwm follows count < active.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_t;

  // Saturate a requested high-time to the full period length 2**n.
  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned n);
    int unsigned max_duty;
    max_duty = 32'd1 << n;
    return (duty > max_duty) ? max_duty : duty;
  endfunction

endpackage

// File: rtl/pwm_gen_wrap_detect.sv
// Period-wrap detector: flags the MAX -> 0 step of the upstream counter.
// A jump to 0 from any other value (upstream reset) is not a wrap.
module wrap_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic [N-1:0] count,
  output logic         wrap_det
);

  logic [N-1:0] count_d;

  // One-cycle delayed copy of the counter value.
  always_ff @(posedge clk) begin
    if (!aresetn) count_d <= '0;
    else          count_d <= count;
  end

  assign wrap_det = (count == '0) && (count_d == {N{1'b1}});

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: duty word enters a shadow register over valid/ready and is
// promoted to the active register only at a period wrap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | output held low, waiting for en
// SYNC  | en seen, output low until the next period wrap
// RUN   | output follows count < duty
// DRAIN | en dropped, finish the current period then return to IDLE
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         en,
  input  logic [N-1:0] count,
  input  logic         duty_valid,
  output logic         duty_ready,
  input  logic [N:0]   duty,
  output logic         pwm,
  output logic         wrap,
  output logic         busy
);

  localparam int DW = N + 1;

  pwm_state_t    state;
  pwm_state_t    state_next;
  logic [DW-1:0] active;
  logic [DW-1:0] shadow;
  logic          pending;
  logic          pwm_next;
  logic          wrap_det;
  logic [DW-1:0] duty_next;
  logic          count_lt;

  wrap_detect #(.N(N)) u_wrap_detect (
    .clk      (clk),
    .aresetn  (aresetn),
    .count    (count),
    .wrap_det (wrap_det)
  );

  assign duty_ready = !pending;
  assign duty_next  = (wrap_det && pending) ? shadow : active;
  assign count_lt   = ({1'b0, count} < duty_next);

  // Shadow/active duty registers and the handshake pending flag.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (wrap_det && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (duty_valid && !pending) begin
      shadow  <= DW'(clamp_duty(32'(duty), N));
      pending <= 1'b1;
    end
  end

  // State register with registered pwm, wrap and busy outputs.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= IDLE;
      pwm   <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      pwm   <= pwm_next;
      wrap  <= wrap_det;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state and next-pwm decode.
  always_comb begin
    state_next = state;
    pwm_next   = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = SYNC;
      end
      SYNC: begin
        if (!en) begin
          state_next = IDLE;
        end else if (wrap_det) begin
          state_next = RUN;
          pwm_next   = (duty_next != '0);
        end
      end
      RUN: begin
        pwm_next = count_lt;
        if (!en) state_next = DRAIN;
      end
      DRAIN: begin
        pwm_next = count_lt;
        if (wrap_det) begin
          if (en) begin
            state_next = RUN;
          end else begin
            state_next = IDLE;
            pwm_next   = 1'b0;
          end
        end else if (en) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
